// File: rtl/alu_seq_if.sv
// alu_seq_if: request, ALU-drive and response signals of the multi-byte ALU sequencer.
// Optional req_cin is present only when ALU_SEQ_CIN_EN is defined.
`default_nettype none

interface alu_seq_if #(
  parameter int BYTES = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [8*BYTES-1:0]   req_a;
  logic [8*BYTES-1:0]   req_b;
`ifdef ALU_SEQ_CIN_EN
  logic                 req_cin;
`endif
  logic [3:0]           alu_ctrl;
  logic [7:0]           alu_a;
  logic [7:0]           alu_b;
  logic                 alu_cin;
  logic [7:0]           alu_out;
  logic                 alu_cout;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [8*BYTES-1:0]   rsp_result;
  logic                 rsp_carry;

`ifdef ALU_SEQ_CIN_EN
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, alu_out, alu_cout, rsp_ready,
    output req_ready, alu_ctrl, alu_a, alu_b, alu_cin, rsp_valid, rsp_result, rsp_carry
  );
  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, alu_out, alu_cout, rsp_ready,
    input  req_ready, alu_ctrl, alu_a, alu_b, alu_cin, rsp_valid, rsp_result, rsp_carry
  );
`else
  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_out, alu_cout, rsp_ready,
    output req_ready, alu_ctrl, alu_a, alu_b, alu_cin, rsp_valid, rsp_result, rsp_carry
  );
  modport master (
    output req_valid, req_op, req_a, req_b, alu_out, alu_cout, rsp_ready,
    input  req_ready, alu_ctrl, alu_a, alu_b, alu_cin, rsp_valid, rsp_result, rsp_carry
  );
`endif
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module  : alu_seq
// Brief   : Byte-serial sequencer driving an 8-bit ALU over BYTES-wide operands,
//           LSB first, with carry chaining. Optional macro ALU_SEQ_CIN_EN adds req_cin.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq #(
  parameter int BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  localparam int         c_idx_w  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(BYTES - 1);

  // ALU opcodes, matching the definitions package encoding
  localparam logic [3:0] c_k_add  = 4'd0;
  localparam logic [3:0] c_k_addc = 4'd1;
  localparam logic [3:0] c_k_and  = 4'd2;
  localparam logic [3:0] c_k_or   = 4'd3;
  localparam logic [3:0] c_k_neg  = 4'd4;

  localparam logic [1:0] c_op_add = 2'd0;
  localparam logic [1:0] c_op_and = 2'd1;
  localparam logic [1:0] c_op_or  = 2'd2;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         r_op;
  logic [8*BYTES-1:0] r_a;
  logic [8*BYTES-1:0] r_b;
`ifdef ALU_SEQ_CIN_EN
  logic               r_cin;
`endif
  logic [c_idx_w-1:0] r_idx;
  logic               r_carry;
  logic [8*BYTES-1:0] r_acc;
  logic [8*BYTES-1:0] r_result;
  logic               r_rsp_carry;

  logic [3:0]         w_ctrl;
  logic [7:0]         w_alu_a;
  logic [7:0]         w_alu_b;
  logic               w_alu_cin;
  logic [8*BYTES-1:0] w_acc_next;
  logic [c_idx_w+2:0] w_bit_base;

  assign w_bit_base = {r_idx, 3'b000};

  always_comb begin
    w_ctrl    = c_k_add;
    w_alu_a   = 8'd0;
    w_alu_b   = 8'd0;
    w_alu_cin = 1'b0;
    if (r_state == c_st_run) begin
      w_alu_a = r_a[w_bit_base +: 8];
      w_alu_b = r_b[w_bit_base +: 8];
      case (r_op)
        c_op_add: begin
          if (r_idx == '0) begin
`ifdef ALU_SEQ_CIN_EN
            w_ctrl    = c_k_addc;
            w_alu_cin = r_cin;
`else
            w_ctrl    = c_k_add;
`endif
          end else begin
            w_ctrl    = c_k_addc;
            w_alu_cin = r_carry;
          end
        end
        c_op_and: w_ctrl = c_k_and;
        c_op_or:  w_ctrl = c_k_or;
        default:  w_ctrl = c_k_neg;
      endcase
    end
  end

  // Accumulator with the current ALU byte merged in; feeds the result register on the last byte
  always_comb begin
    w_acc_next                 = r_acc;
    w_acc_next[w_bit_base +: 8] = bus.alu_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_op        <= 2'd0;
      r_a         <= '0;
      r_b         <= '0;
`ifdef ALU_SEQ_CIN_EN
      r_cin       <= 1'b0;
`endif
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_acc       <= '0;
      r_result    <= '0;
      r_rsp_carry <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (bus.req_valid) begin
            r_op    <= bus.req_op;
            r_a     <= bus.req_a;
            r_b     <= bus.req_b;
            r_idx   <= '0;
            r_acc   <= '0;
`ifdef ALU_SEQ_CIN_EN
            r_cin   <= bus.req_cin;
            r_carry <= (bus.req_op == c_op_add) ? bus.req_cin : 1'b0;
`else
            r_carry <= 1'b0;
`endif
            r_state <= c_st_run;
          end
        end
        c_st_run: begin
          r_acc   <= w_acc_next;
          r_carry <= (r_op == c_op_add) ? bus.alu_cout : 1'b0;
          r_idx   <= r_idx + c_idx_w'(1);
          if (r_idx == c_last) begin
            r_result    <= w_acc_next;
            r_rsp_carry <= (r_op == c_op_add) ? bus.alu_cout : 1'b0;
            r_state     <= c_st_done;
          end
        end
        c_st_done: begin
          if (bus.rsp_ready) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == c_st_idle);
  assign bus.rsp_valid  = (r_state == c_st_done);
  assign bus.rsp_result = r_result;
  assign bus.rsp_carry  = r_rsp_carry;
  assign bus.alu_ctrl   = w_ctrl;
  assign bus.alu_a      = w_alu_a;
  assign bus.alu_b      = w_alu_b;
  assign bus.alu_cin    = w_alu_cin;

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Multi-byte operation sequencer that sits directly upstream of the 8-bit combinational ALU. It accepts one wide request (BYTES × 8 bits), drives the ALU one byte per cycle, least-significant byte first, and chains carry through `kAdd`/`kAddC`. It collects the ALU results into a wide result register and returns the result with a final carry over a valid/ready handshake.

## Interface
Parameters:
- `BYTES`, default 4: operand width in bytes; legal range 1..16.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request (IDLE only).
- `req_op` in 2: 0 = add, 1 = and, 2 = or, 3 = neg (bitwise invert of `a`).
- `req_a` in 8*BYTES: operand A.
- `req_b` in 8*BYTES: operand B (ignored for neg).
- `req_cin` in 1: carry into byte 0. Present only with `ALU_SEQ_CIN_EN`.
- `alu_ctrl` out 4: ALU opcode, using the `definitions` package values.
- `alu_a` out 8: ALU operand A.
- `alu_b` out 8: ALU operand B.
- `alu_cin` out 1: ALU carry in.
- `alu_out` in 8: ALU result.
- `alu_cout` in 1: ALU carry out.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_result` out 8*BYTES: wide result.
- `rsp_carry` out 1: final carry (add); 0 for logical ops.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid` && `req_ready`: latch `req_op`, `req_a`, `req_b` (and `req_cin`), clear byte index to 0, load the carry register, go to RUN.
- **RUN**
  - Index `i` = 0..BYTES-1.
  - ALU ports are driven combinationally from the latched byte `i`: `alu_a` = A[8i+7:8i], `alu_b` = B[8i+7:8i].
  - add, i = 0: `alu_ctrl` = `kAdd`, `alu_cin` = 0 (or `kAddC` with latched cin, see Configuration).
  - add, i > 0: `kAddC`, `alu_cin` = carry register.
  - and / or / neg: `kAnd` / `kOr` / `kNeg`; `alu_cin` = 0.
  - Each edge: result byte `i` ← `alu_out`. For add, carry register ← `alu_cout`; for logical ops, carry register ← 0. Then `i` increments.
  - On the edge that captures byte BYTES-1, go to DONE.
- **DONE**
  - `rsp_valid` = 1; `rsp_result` and `rsp_carry` are held stable.
  - On `rsp_ready` = 1, go to IDLE.
  - With `rsp_ready` held low, remain in DONE indefinitely.
- Outside RUN: `alu_ctrl` = `kAdd`, `alu_a` = `alu_b` = 0, `alu_cin` = 0.
- While not in IDLE, `req_valid` is ignored (`req_ready` = 0). No accept occurs in the DONE→IDLE cycle.
- Arithmetic wraps modulo 2^(8*BYTES). Overflow is reported only via `rsp_carry`.
- BYTES = 1: RUN lasts one cycle; byte 0 rules apply.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - state → IDLE; index, carry and result registers → 0.
  - `req_ready` = 1, `rsp_valid` = 0, `rsp_result` = 0, `rsp_carry` = 0.
  - ALU outputs go to their idle values.
  - The in-flight request is discarded; no partial response is produced.
- Latency: request accepted at edge E0, `rsp_valid` high after edge E_BYTES (BYTES cycles). Minimum issue interval is BYTES+2 cycles.
- The ALU path is combinational within one cycle: `alu_*` outputs → ALU → `alu_out`/`alu_cout` → capture registers.
- `rsp_result` and `rsp_carry` change only on the transition into DONE and on reset.

## Configuration
- Macro: `ALU_SEQ_CIN_EN`.
- **Defined**
  - Port `req_cin` exists and is latched at accept.
  - For add, byte 0 uses `kAddC` with `alu_cin` = latched cin.
  - Logical ops ignore `req_cin`.
- **Undefined**
  - No `req_cin` port.
  - For add, byte 0 uses `kAdd` with `alu_cin` = 0.

## Test plan
- **Carry ripple.** BYTES=4, add 0x00FF_FFFF + 0x0000_0001 → `rsp_result` = 0x0100_0000, `rsp_carry` = 0, `rsp_valid` 4 cycles after accept. `alu_ctrl` sequence: `kAdd`, `kAddC`, `kAddC`, `kAddC`.
- **Wrap.** Add 0xFFFF_FFFF + 0x0000_0001 → result 0x0000_0000, carry 1. Add 0x1234_5678 + 0x1111_1111 → 0x2345_6789, carry 0.
- **Logical ops.**
  - and 0xF0F0_AAAA, 0xFF00_0F0F → 0xF000_0A0A.
  - or, same operands → 0xFFF0_AFAF.
  - neg 0x0000_00FF → 0xFFFF_FF00.
  - All three: `rsp_carry` = 0.
- **Backpressure.**
  - Hold `rsp_ready` = 0 for 10 cycles in DONE → `rsp_valid` and the result stay stable, `req_ready` = 0.
  - A second `req_valid` during RUN or DONE is not accepted.
  - Raise `rsp_ready` → IDLE next cycle, then accept.
- **Reset mid-operation.** Assert `rst_n` = 0 after 2 RUN cycles → outputs go immediately to their reset values. After release, a new add 0x0000_0002 + 0x0000_0003 → 0x0000_0005.
- **Macro defined.** With `ALU_SEQ_CIN_EN`, BYTES=1, add 0xFF + 0x00 with `req_cin` = 1 → result 0x00, carry 1; byte 0 uses `kAddC`.
